// File: rtl/por_domain_sequencer.sv
// Power-on reset sequencer: brings up N_DOM reset domains in order, with timeout/retry,
// sticky failure map and run-time lock-loss recovery from the failing domain onward.
module por_domain_sequencer #(
  parameter int N_DOM     = 4,
  parameter int RST_CYC   = 16,
  parameter int TMO_W     = 16,
  parameter int TMO       = 50000,
  parameter int MAX_RETRY = 3,
  parameter logic [N_DOM-1:0] MON_MASK = {N_DOM{1'b1}}
) (
  input  logic             STUP_CLK,
  input  logic             SYS_RST,
  input  logic             RESTART,
  input  logic [N_DOM-1:0] DOM_DONE,
  output logic [N_DOM-1:0] DOM_RST,
  output logic             RUN,
  output logic             FAIL,
  output logic [N_DOM-1:0] FAIL_MAP,
  output logic [3:0]       CUR_DOM,
  output logic [3:0]       RETRY_CNT,
  output logic [2:0]       STATE
);

  localparam int HOLD_W = $clog2(RST_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ASSERT = 3'd1,
    S_WAIT   = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t             state;
  logic [HOLD_W-1:0]  hold;
  logic [TMO_W-1:0]   timer;
  logic [N_DOM-1:0]   sync1;
  logic [N_DOM-1:0]   ds;
  logic [15:0]        ds_ext;
  logic [N_DOM-1:0]   lost;

  assign STATE  = state;
  assign ds_ext = 16'(ds);
  assign lost   = ~ds & MON_MASK;

  // Reset vector for a given current domain: higher domains always held, current one optional.
  function automatic logic [N_DOM-1:0] rst_mask(input logic [3:0] idx, input logic incl);
    logic [N_DOM-1:0] r;
    for (int k = 0; k < N_DOM; k++)
      r[k] = (4'(k) > idx) || (incl && (4'(k) == idx));
    return r;
  endfunction

  function automatic logic [3:0] lowest(input logic [N_DOM-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int k = N_DOM - 1; k >= 0; k--)
      if (v[k]) r = 4'(k);
    return r;
  endfunction

  // DOM_DONE sources are asynchronous to STUP_CLK.
  always_ff @(posedge STUP_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      sync1 <= '0;
      ds    <= '0;
    end else begin
      sync1 <= DOM_DONE;
      ds    <= sync1;
    end
  end

  always_ff @(posedge STUP_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state     <= S_IDLE;
      hold      <= '0;
      timer     <= '0;
      DOM_RST   <= '1;
      RUN       <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_MAP  <= '0;
      CUR_DOM   <= 4'd0;
      RETRY_CNT <= 4'd0;
    end else if (RESTART) begin
      state     <= S_ASSERT;
      hold      <= '0;
      timer     <= '0;
      DOM_RST   <= '1;
      RUN       <= 1'b0;
      FAIL      <= 1'b0;
      CUR_DOM   <= 4'd0;
      RETRY_CNT <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_ASSERT;
          CUR_DOM <= 4'd0;
          hold    <= '0;
          DOM_RST <= '1;
        end
        S_ASSERT: begin
          if (hold == HOLD_W'(RST_CYC - 1)) begin
            hold    <= '0;
            timer   <= '0;
            state   <= S_WAIT;
            DOM_RST <= rst_mask(CUR_DOM, 1'b0);
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        S_WAIT: begin
          // Done is checked first so it wins over a simultaneous timeout.
          if (ds_ext[CUR_DOM]) begin
            RETRY_CNT <= 4'd0;
            timer     <= '0;
            if (CUR_DOM == 4'(N_DOM - 1)) begin
              state   <= S_RUN;
              RUN     <= 1'b1;
              DOM_RST <= '0;
            end else begin
              CUR_DOM <= CUR_DOM + 4'd1;
              state   <= S_ASSERT;
              hold    <= '0;
              DOM_RST <= rst_mask(CUR_DOM + 4'd1, 1'b1);
            end
          end else if (timer == TMO_W'(TMO - 1)) begin
            timer     <= '0;
            hold      <= '0;
            RETRY_CNT <= RETRY_CNT + 4'd1;
            DOM_RST   <= rst_mask(CUR_DOM, 1'b1);
            if (RETRY_CNT + 4'd1 == 4'(MAX_RETRY)) begin
              state    <= S_FAIL;
              FAIL     <= 1'b1;
              FAIL_MAP <= FAIL_MAP | (rst_mask(CUR_DOM, 1'b1) ^ rst_mask(CUR_DOM, 1'b0));
            end else begin
              state <= S_ASSERT;
            end
          end else if (timer != '1) begin
            timer <= timer + TMO_W'(1);
          end
        end
        S_RUN: begin
          if (|lost) begin
            CUR_DOM   <= lowest(lost);
            RETRY_CNT <= 4'd0;
            hold      <= '0;
            state     <= S_ASSERT;
            RUN       <= 1'b0;
            DOM_RST   <= rst_mask(lowest(lost), 1'b1);
          end
        end
        S_FAIL: begin
          state <= S_FAIL;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_por_domain_sequencer.sv
// Directed bench for por_domain_sequencer: bring-up, retry/fail, lock-loss recovery,
// monitor mask, restart and the done-vs-timeout boundary.
module tb_por_domain_sequencer;

  logic       clk;
  logic       sys_rst;
  logic       restart;
  logic [2:0] dom_done;
  logic [2:0] dom_rst;
  logic       run;
  logic       fail;
  logic [2:0] fail_map;
  logic [3:0] cur_dom;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  logic       restart_m;
  logic [2:0] dom_done_m;
  logic [2:0] dom_rst_m;
  logic       run_m;
  logic       fail_m;
  logic [2:0] fail_map_m;
  logic [3:0] cur_dom_m;
  logic [3:0] retry_cnt_m;
  logic [2:0] state_m;

  int passed = 0;
  int total  = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_v;

  por_domain_sequencer #(
    .N_DOM(3), .RST_CYC(4), .TMO_W(16), .TMO(20), .MAX_RETRY(2), .MON_MASK(3'b111)
  ) dut (
    .STUP_CLK(clk), .SYS_RST(sys_rst), .RESTART(restart), .DOM_DONE(dom_done),
    .DOM_RST(dom_rst), .RUN(run), .FAIL(fail), .FAIL_MAP(fail_map),
    .CUR_DOM(cur_dom), .RETRY_CNT(retry_cnt), .STATE(state)
  );

  por_domain_sequencer #(
    .N_DOM(3), .RST_CYC(4), .TMO_W(16), .TMO(20), .MAX_RETRY(2), .MON_MASK(3'b011)
  ) dut_m (
    .STUP_CLK(clk), .SYS_RST(sys_rst), .RESTART(restart_m), .DOM_DONE(dom_done_m),
    .DOM_RST(dom_rst_m), .RUN(run_m), .FAIL(fail_m), .FAIL_MAP(fail_map_m),
    .CUR_DOM(cur_dom_m), .RETRY_CNT(retry_cnt_m), .STATE(state_m)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Driver: advance n rising edges, land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    sys_rst    = 1'b1;
    restart    = 1'b0;
    restart_m  = 1'b0;
    dom_done   = 3'b111;
    dom_done_m = 3'b111;
    tick(3);

    chk("rst_state", state, 0);
    chk("rst_dom_rst", dom_rst, 3'b111);
    chk("rst_run", run, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_map", fail_map, 0);
    chk("rst_cur_dom", cur_dom, 0);
    chk("rst_retry", retry_cnt, 0);
    sys_rst = 1'b0;

    // Normal bring-up trace of DOM_RST, edges 1..16 after release
    repeat (4) exp_q.push_back(3'b111);
    repeat (5) exp_q.push_back(3'b110);
    repeat (5) exp_q.push_back(3'b100);
    repeat (2) exp_q.push_back(3'b000);
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      exp_v = exp_q.pop_front();
      chk("bringup_dom_rst", dom_rst, exp_v);
      if (c == 1)  chk("bringup_state_c1", state, 1);
      if (c == 5)  chk("bringup_state_c5", state, 2);
      if (c == 15) chk("bringup_run_c15", run, 0);
    end
    chk("bringup_run", run, 1);
    chk("bringup_state", state, 3);
    chk("bringup_cur_dom", cur_dom, 2);
    chk("bringup_run_m", run_m, 1);

    // Lock loss on domain 1 for two cycles
    dom_done[1] = 1'b0;
    tick(2);
    dom_done[1] = 1'b1;
    chk("ll_run_hold", run, 1);
    tick(1);
    chk("ll_run_drop", run, 0);
    chk("ll_dom_rst", dom_rst, 3'b110);
    chk("ll_cur_dom", cur_dom, 1);
    chk("ll_state", state, 1);
    chk("ll_retry", retry_cnt, 0);
    for (int c = 0; c < 9; c++) begin
      tick(1);
      chk("ll_dom0_kept", dom_rst[0], 0);
      chk("ll_run_low", run, 0);
    end
    tick(1);
    chk("ll_run_back", run, 1);
    chk("ll_dom_rst_back", dom_rst, 3'b000);

    // Masked domain 2 on dut_m: loss is ignored in RUN
    dom_done_m[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      chk("mask_run", run_m, 1);
      chk("mask_dom_rst", dom_rst_m, 3'b000);
    end
    dom_done_m[2] = 1'b1;

    // Restart pulse, then domain 2 times out once
    dom_done = 3'b011;
    restart  = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("rs1_state", state, 1);
    chk("rs1_dom_rst", dom_rst, 3'b111);
    chk("rs1_run", run, 0);
    tick(14);
    chk("d2_wait_state", state, 2);
    chk("d2_wait_cur", cur_dom, 2);
    chk("d2_wait_dom_rst", dom_rst, 3'b000);
    tick(19);
    chk("d2_tmo_edge_state", state, 2);
    chk("d2_tmo_edge_retry", retry_cnt, 0);
    tick(1);
    chk("d2_tmo_state", state, 1);
    chk("d2_tmo_retry", retry_cnt, 1);
    chk("d2_tmo_dom_rst", dom_rst, 3'b100);
    tick(5);
    chk("d2_wait2_state", state, 2);
    chk("d2_wait2_retry", retry_cnt, 1);

    // Restart in WAIT of domain 2 with one retry; rerun with domain 1 dead
    dom_done = 3'b101;
    restart  = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("rs2_state", state, 1);
    chk("rs2_cur", cur_dom, 0);
    chk("rs2_retry", retry_cnt, 0);
    chk("rs2_dom_rst", dom_rst, 3'b111);
    tick(9);
    chk("d1_wait_state", state, 2);
    chk("d1_wait_cur", cur_dom, 1);
    chk("d1_wait_dom_rst", dom_rst, 3'b100);
    tick(19);
    chk("d1_w1_end_state", state, 2);
    tick(1);
    chk("d1_tmo1_state", state, 1);
    chk("d1_tmo1_retry", retry_cnt, 1);
    chk("d1_tmo1_dom_rst", dom_rst, 3'b110);
    tick(4);
    chk("d1_w2_state", state, 2);
    chk("d1_w2_dom_rst", dom_rst, 3'b100);
    tick(19);
    chk("d1_w2_end_state", state, 2);
    chk("d1_w2_end_fail", fail, 0);
    tick(1);
    chk("fail_fail", fail, 1);
    chk("fail_map", fail_map, 3'b010);
    chk("fail_retry", retry_cnt, 2);
    chk("fail_cur", cur_dom, 1);
    chk("fail_dom_rst", dom_rst, 3'b110);
    chk("fail_state", state, 4);
    chk("fail_run", run, 0);
    tick(5);
    chk("fail_held_state", state, 4);
    chk("fail_held_fail", fail, 1);

    // Restart out of FAIL, held two cycles; FAIL_MAP stays sticky
    dom_done = 3'b111;
    restart  = 1'b1;
    tick(1);
    chk("rs3_state", state, 1);
    chk("rs3_fail", fail, 0);
    chk("rs3_fail_map", fail_map, 3'b010);
    chk("rs3_dom_rst", dom_rst, 3'b111);
    chk("rs3_retry", retry_cnt, 0);
    tick(1);
    restart = 1'b0;
    chk("rs3_held_state", state, 1);
    tick(14);
    chk("rs3_pre_run", run, 0);
    chk("rs3_pre_dom_rst", dom_rst, 3'b000);
    tick(1);
    chk("rs3_run", run, 1);
    chk("rs3_run_state", state, 3);
    chk("rs3_run_fail_map", fail_map, 3'b010);

    // Asynchronous reset mid-run, then done on domain 0 lands on the last timer cycle
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_dom_rst", dom_rst, 3'b111);
    chk("arst_run", run, 0);
    chk("arst_fail_map", fail_map, 0);
    dom_done = 3'b110;
    tick(2);
    sys_rst = 1'b0;
    tick(5);
    chk("bnd_wait_state", state, 2);
    chk("bnd_wait_cur", cur_dom, 0);
    tick(17);
    dom_done[0] = 1'b1;
    tick(2);
    chk("bnd_pre_state", state, 2);
    chk("bnd_pre_cur", cur_dom, 0);
    tick(1);
    chk("bnd_state", state, 1);
    chk("bnd_cur", cur_dom, 1);
    chk("bnd_retry", retry_cnt, 0);
    chk("bnd_fail_map", fail_map, 0);
    chk("bnd_dom_rst", dom_rst, 3'b110);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
